// File: rtl/uart_rx_word_fifo_if.sv
// Byte-in / word-out bundle for uart_rx_word_fifo.
// master drives bytes and pops, slave is the assembler/FIFO.
interface uart_rx_word_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rdata;
    logic          rdata_ready;
    logic          ferr;
    logic [31:0]   word_data;
    logic          word_valid;
    logic          word_ready;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clear_ovf;
    logic [7:0]    err_cnt;

    modport master (
        output rdata, rdata_ready, ferr, word_ready, clear_ovf,
        input  word_data, word_valid, count, overflow, err_cnt
    );

    modport slave (
        input  rdata, rdata_ready, ferr, word_ready, clear_ovf,
        output word_data, word_valid, count, overflow, err_cnt
    );
endinterface

// File: rtl/uart_rx_word_fifo.sv
// Packs UART bytes little-endian into 32-bit words and queues them.
// Define UART_RX_FERR_DROP_EN to drop framing-error bytes and count them.
module uart_rx_word_fifo #(
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               reset,
    uart_rx_word_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;
    localparam logic [1:0] B3 = 2'd3;

    logic [1:0]    state;
    logic [23:0]   partial;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic          accept;
    logic          ferr_hit;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

`ifdef UART_RX_FERR_DROP_EN
    logic [7:0] err_cnt;

    assign accept   = bus.rdata_ready & ~bus.ferr;
    assign ferr_hit = bus.rdata_ready & bus.ferr;

    // Saturating count of strobes rejected for framing errors.
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= 8'd0;
        else if (ferr_hit && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    logic       unused_ferr;
    logic [7:0] err_cnt;

    assign unused_ferr = bus.ferr;
    assign accept      = bus.rdata_ready;
    assign ferr_hit    = 1'b0;
    assign err_cnt     = 8'd0;
`endif

    assign full  = (count == FULL_CNT);
    assign push  = accept && (state == B3);
    assign pop   = (count != '0) && bus.word_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Byte-lane FSM: collect bytes 0..2, byte 3 completes the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= B0;
            partial <= '0;
        end else if (ferr_hit) begin
            state <= B0;
        end else if (accept) begin
            case (state)
                B0: partial[7:0]   <= bus.rdata;
                B1: partial[15:8]  <= bus.rdata;
                B2: partial[23:16] <= bus.rdata;
                default: ;
            endcase
            state <= state + 2'd1;
        end
    end

    // Storage array; written only when a slot is free or freed this cycle.
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            mem[wr_ptr] <= {bus.rdata, partial};
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (bus.clear_ovf)
            overflow <= 1'b0;
    end

    assign bus.word_data  = mem[rd_ptr];
    assign bus.word_valid = (count != '0);
    assign bus.count      = count;
    assign bus.overflow   = overflow;
    assign bus.err_cnt    = err_cnt;
endmodule
